// File: rtl/wshb_mire.sv
// wshb_mire: Wishbone master painting an 8-bar colour test pattern into the framebuffer; define MIRE_GRID_EN to overlay a 16-pixel white grid.
module wshb_mire #(
  parameter int          HDISP    = 800,
  parameter int          VDISP    = 480,
  parameter logic [31:0] BASE_ADR = 32'h0,
  parameter int          BURST    = 64
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        en,
  output logic        cyc,
  output logic        stb,
  output logic        we,
  output logic [31:0] adr,
  output logic [31:0] dat_ms,
  output logic [3:0]  sel,
  output logic [2:0]  cti,
  output logic [1:0]  bte,
  input  logic        ack,
  input  logic        err,
  output logic        frame_done
);
  localparam int XW = HDISP > 1 ? $clog2(HDISP) : 1;
  localparam int YW = VDISP > 1 ? $clog2(VDISP) : 1;
  localparam int CW = BURST > 1 ? $clog2(BURST) : 1;
  localparam int W  = HDISP >= 8 ? HDISP / 8 : 1;
  localparam int BW = W > 1 ? $clog2(W) : 1;
  localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                       24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
  typedef enum logic {RELEASE, WRITE} state_t;
  state_t          state, state_nx;
  logic [XW-1:0]   x;
  logic [YW-1:0]   y;
  logic [CW-1:0]   cnt;
  logic [BW-1:0]   bar_cnt;
  logic [2:0]      bar;
  logic [23:0]     rgb;
  logic            done, last_x, last_y, last_b, bar_end;
  assign cyc     = state == WRITE;
  assign stb     = cyc;
  assign we      = 1'b1;
  assign sel     = 4'hF;
  assign cti     = 3'b000;
  assign bte     = 2'b00;
  assign done    = cyc && ack && !err;
  assign last_x  = x == XW'(HDISP - 1);
  assign last_y  = y == YW'(VDISP - 1);
  assign last_b  = cnt == CW'(BURST - 1);
  assign bar_end = bar_cnt == BW'(W - 1);
`ifdef MIRE_GRID_EN
  assign rgb = (4'(x) == 4'd0 || 4'(y) == 4'd0) ? 24'hFFFFFF : BARS[bar];
`else
  assign rgb = BARS[bar];
`endif
  assign dat_ms = {8'h00, rgb};
  // err wins over ack: the failed pixel is retried after a single release cycle
  always_comb begin
    state_nx = state == RELEASE ? (en ? WRITE : RELEASE)
             : (err || (ack && (last_b || !en))) ? RELEASE : WRITE;
  end
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state      <= RELEASE;
      frame_done <= 1'b0;
      x          <= '0;
      y          <= '0;
      cnt        <= '0;
      bar        <= '0;
      bar_cnt    <= '0;
      adr        <= BASE_ADR;
    end else begin
      state      <= state_nx;
      frame_done <= done && last_x && last_y;
      if (done) begin
        cnt     <= last_b ? '0 : cnt + 1'b1;
        x       <= last_x ? '0 : x + 1'b1;
        y       <= !last_x ? y : last_y ? '0 : y + 1'b1;
        adr     <= (last_x && last_y) ? BASE_ADR : adr + 32'd4;
        bar_cnt <= (last_x || bar_end) ? '0 : bar_cnt + 1'b1;
        bar     <= last_x ? '0 : (bar_end && bar != 3'd7) ? bar + 3'd1 : bar;
      end
    end
  end
endmodule

// File: tb/tb_wshb_mire.sv
// tb_wshb_mire: directed vector table plus hand-written sequences for stall, err, en and reset on a 16x4 frame.
module tb_wshb_mire;
  logic        sys_clk = 0, sys_rst = 1, en = 1, ack = 0, err = 0;
  logic        cyc, stb, we, frame_done;
  logic [31:0] adr, dat_ms;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        hold_ack = 0, err_req = 0, err_taken = 0;
  logic [31:0] err_adr = 0;
  int          total = 0, bad = 0, acks = 0;
  logic [31:0] log_adr[$], log_dat[$];
  int          rel_at[$], fd_at[$];
  typedef struct {int idx; logic [31:0] adr; logic [31:0] dat;} vec_t;
  vec_t vecs[15];

  always #5 sys_clk = ~sys_clk;

  wshb_mire #(.HDISP(16), .VDISP(4), .BASE_ADR(32'h100), .BURST(8)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .en(en), .cyc(cyc), .stb(stb), .we(we),
    .adr(adr), .dat_ms(dat_ms), .sel(sel), .cti(cti), .bte(bte),
    .ack(ack), .err(err), .frame_done(frame_done));

  // slave: answers one cycle after stb, can stall or fail one chosen address
  always @(posedge sys_clk) begin
    if (sys_rst) begin
      ack <= 0;
      err <= 0;
      err_taken <= 0;
    end else begin
      ack <= cyc && stb && !ack && !err && !hold_ack && !(err_req && !err_taken && adr == err_adr);
      err <= cyc && stb && !ack && !err && !hold_ack && err_req && !err_taken && adr == err_adr;
      if (err) err_taken <= 1;
    end
  end

  always @(posedge sys_clk) begin
    if (!sys_rst) begin
      if (cyc && stb && ack && !err) begin
        acks <= acks + 1;
        log_adr.push_back(adr);
        log_dat.push_back(dat_ms);
      end
      if (!cyc && acks > 0) rel_at.push_back(acks);
      if (frame_done) fd_at.push_back(acks);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_acks(input int n);
    for (int i = 0; i < 3000 && acks < n; i++) @(negedge sys_clk);
    chk("ack_timeout", 32'(acks >= n), 1);
  endtask

  task automatic wait_pending();
    for (int i = 0; i < 100 && !(stb && !ack && !err); i++) @(negedge sys_clk);
    chk("pending_timeout", 32'(stb && !ack && !err), 1);
  endtask

  initial begin
    logic [31:0] a0, d0, d2, d15, d_res;
    int n0, hi;
    int exp_rel[9];
    exp_rel = '{72, 80, 83, 88, 96, 104, 112, 120, 128};
`ifdef MIRE_GRID_EN
    d2 = 32'h00FFFFFF; d15 = 32'h00FFFFFF; d_res = 32'h00FFFFFF;
`else
    d2 = 32'h00FFFF00; d15 = 32'h00000000; d_res = 32'h0000FF00;
`endif
    vecs[0]  = '{0,  32'h100, 32'h00FFFFFF};
    vecs[1]  = '{1,  32'h104, 32'h00FFFFFF};
    vecs[2]  = '{2,  32'h108, d2};
    vecs[3]  = '{15, 32'h13C, d15};
    vecs[4]  = '{16, 32'h140, 32'h00FFFFFF};
    vecs[5]  = '{18, 32'h148, 32'h00FFFF00};
    vecs[6]  = '{19, 32'h14C, 32'h00FFFF00};
    vecs[7]  = '{20, 32'h150, 32'h0000FFFF};
    vecs[8]  = '{22, 32'h158, 32'h0000FF00};
    vecs[9]  = '{24, 32'h160, 32'h00FF00FF};
    vecs[10] = '{26, 32'h168, 32'h00FF0000};
    vecs[11] = '{28, 32'h170, 32'h000000FF};
    vecs[12] = '{31, 32'h17C, 32'h00000000};
    vecs[13] = '{63, 32'h1FC, 32'h00000000};
    vecs[14] = '{64, 32'h100, 32'h00FFFFFF};
    repeat (3) @(negedge sys_clk);
    chk("rst_outputs", {29'd0, cyc, stb, frame_done}, 0);
    sys_rst = 0;
    @(negedge sys_clk);
    chk("first_cyc_stb", {30'd0, cyc, stb}, 3);
    chk("first_adr", adr, 32'h100);
    chk("first_dat", dat_ms, 32'h00FFFFFF);
    chk("constants", {22'd0, we, sel, cti, bte}, {22'd0, 1'b1, 4'hF, 3'b000, 2'b00});
    wait_acks(66);
    for (int i = 0; i < 15; i++) begin
      chk($sformatf("vec%0d_adr", vecs[i].idx), vecs[i].idx < log_adr.size() ? log_adr[vecs[i].idx] : 32'hX, vecs[i].adr);
      chk($sformatf("vec%0d_dat", vecs[i].idx), vecs[i].idx < log_dat.size() ? log_dat[vecs[i].idx] : 32'hX, vecs[i].dat);
    end
    for (int i = 0; i < 8; i++)
      chk($sformatf("release%0d", i), rel_at.size() > i ? rel_at[i] : -1, 8 * (i + 1));
    chk("frame_done_count1", fd_at.size(), 1);
    chk("frame_done_at1", fd_at.size() > 0 ? fd_at[0] : -1, 64);
    wait_pending();
    hold_ack = 1;
    a0 = adr; d0 = dat_ms; n0 = acks;
    repeat (5) begin
      @(negedge sys_clk);
      chk("stall_hold", {28'd0, stb, adr == a0, dat_ms == d0, acks == n0}, 32'hF);
    end
    hold_ack = 0;
    wait_acks(n0 + 1);
    chk("stall_done_adr", log_adr.size() > n0 ? log_adr[n0] : 32'hX, a0);
    err_adr = 32'h14C;
    err_req = 1;
    for (int i = 0; i < 1000 && !err; i++) @(negedge sys_clk);
    chk("err_seen", 32'(err), 1);
    n0 = acks;
    chk("err_ack_index", n0, 83);
    @(negedge sys_clk);
    chk("err_release", 32'(cyc), 0);
    @(negedge sys_clk);
    chk("err_retry_cyc", {30'd0, cyc, stb}, 3);
    chk("err_retry_adr", adr, 32'h14C);
    chk("err_retry_dat", dat_ms, 32'h00FFFF00);
    err_req = 0;
    wait_acks(n0 + 1);
    chk("err_logged_adr", log_adr.size() > n0 ? log_adr[n0] : 32'hX, 32'h14C);
    wait_acks(130);
    chk("frame_done_count2", fd_at.size(), 2);
    chk("frame_done_at2", fd_at.size() > 1 ? fd_at[1] : -1, 128);
    for (int i = 0; i < 9; i++)
      chk($sformatf("release%0d", i + 8), rel_at.size() > i + 8 ? rel_at[i + 8] : -1, exp_rel[i]);
    wait_acks(133);
    wait_pending();
    chk("en_pending_adr", adr, 32'h114);
    en = 0;
    wait_acks(134);
    hi = 0;
    repeat (10) begin
      if (cyc) hi++;
      @(negedge sys_clk);
    end
    chk("en_idle_cycles_high", hi, 0);
    chk("en_completed_adr", log_adr.size() > 133 ? log_adr[133] : 32'hX, 32'h114);
    en = 1;
    for (int i = 0; i < 10 && !cyc; i++) @(negedge sys_clk);
    chk("resume_adr", adr, 32'h118);
    chk("resume_dat", dat_ms, d_res);
    wait_pending();
    sys_rst = 1;
    @(negedge sys_clk);
    chk("midrst_outputs", {29'd0, cyc, stb, frame_done}, 0);
    sys_rst = 0;
    @(negedge sys_clk);
    chk("midrst_restart_adr", adr, 32'h100);
    chk("midrst_restart_cyc", 32'(cyc), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
